// File: rtl/mem_write_encoder.sv
`default_nettype none
// ============================================================================
// mem_write_encoder: big-endian SW/SH/SB store path; sub-word stores are
// merged into the addressed word by read-modify-write.    Rev 1.0
// ============================================================================
module mem_write_encoder #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [1:0]            req_size,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [31:0]           mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic                  mem_wr_en,
  output logic [31:0]           mem_wr_data,
  input  logic                  mem_wr_ack
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, FIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic                  half_q, half_d;
  logic [1:0]            off_q, off_d;
  logic                  err_q, err_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  accept;
  logic [31:0]           merged;

  assign req_ready   = (state_q == IDLE) && !rst;
  assign accept      = req_valid && req_ready;
  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;
  assign done        = done_q;
  assign error       = error_q;

  // Offset 0 is the most significant byte of the word.
  always_comb begin
    merged = mem_rd_data;
    if (half_q) begin
      if (off_q[1]) merged[15:0]  = data_q;
      else          merged[31:16] = data_q;
    end else begin
      case (off_q)
        2'd0:    merged[31:24] = data_q[7:0];
        2'd1:    merged[23:16] = data_q[7:0];
        2'd2:    merged[15:8]  = data_q[7:0];
        default: merged[7:0]   = data_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    half_d    = half_q;
    off_d     = off_q;
    err_d     = err_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          data_d = req_data[15:0];
          half_d = (req_size == 2'd1);
          off_d  = req_addr[1:0];
          err_d  = 1'b0;
          case (req_size)
            2'd0: begin
              wr_data_d = req_data;
              state_d   = WRITE;
            end
            2'd1: begin
              if (req_addr[0]) begin
                err_d   = 1'b1;
                state_d = FIN;
              end else begin
                state_d = READ;
              end
            end
            2'd2:    state_d = READ;
            default: begin
              err_d   = 1'b1;
              state_d = FIN;
            end
          endcase
        end
      end
      READ, WAIT: begin
        if (mem_rd_valid) begin
          wr_data_d = merged;
          state_d   = WRITE;
        end else begin
          state_d   = WAIT;
        end
      end
      WRITE: if (mem_wr_ack) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_en_d = (state_d == READ);
    wr_en_d = (state_d == WRITE);
    done_d  = (state_d == FIN);
    error_d = (state_d == FIN) && err_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      half_q    <= 1'b0;
      off_q     <= 2'd0;
      err_q     <= 1'b0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      half_q    <= half_d;
      off_q     <= off_d;
      err_q     <= err_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_write_encoder.sv
`default_nettype none
// ============================================================================
// tb_mem_write_encoder: directed stimulus against a latency-programmable
// memory responder.    Rev 1.0
// ============================================================================
module tb_mem_write_encoder;
  localparam int ADDR_WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_data;
  logic [1:0]            req_size;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic [31:0]           mem_rd_data;
  logic                  mem_rd_valid;
  logic                  mem_wr_en;
  logic [31:0]           mem_wr_data;
  logic                  mem_wr_ack;

  logic        model_rd_valid, model_ack, spur_ack;
  logic [31:0] mem_word;
  int          rd_lat, ack_lat;

  assign mem_rd_valid = model_rd_valid;
  assign mem_wr_ack   = model_ack | spur_ack;
  assign mem_rd_data  = mem_word;

  mem_write_encoder #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size),
    .done(done), .error(error), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  int accept_cnt = 0, rd_pulses = 0, wr_en_cyc = 0, wr_done = 0;
  int done_cnt = 0, err_cnt = 0, unstable = 0, err_wo_done = 0;
  int accept_cyc = 0, rd_cyc = 0, wr_cyc = 0, done_cyc = 0;
  int rd_cnt = -1, wr_run = 0;
  logic [31:0] wr_data_seen = '0, wr_addr_seen = '0, prev_wr_data = '0;
  logic        prev_wr_en = 1'b0;

  // Memory responder and event monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (req_valid && req_ready) begin accept_cnt++; accept_cyc = cyc; end
    if (mem_rd_en) begin rd_pulses++; rd_cyc = cyc; rd_cnt = rd_lat; end
    model_rd_valid = 1'b0;
    if (rd_cnt == 0) begin model_rd_valid = 1'b1; rd_cnt = -1; end
    else if (rd_cnt > 0) rd_cnt--;
    if (mem_wr_en) begin
      wr_en_cyc++;
      if (!prev_wr_en) wr_cyc = cyc;
      else if (mem_wr_data != prev_wr_data) unstable++;
      wr_run++;
    end else begin
      wr_run = 0;
    end
    model_ack = mem_wr_en && (wr_run == ack_lat + 1);
    if (mem_wr_en && (model_ack || spur_ack)) begin
      wr_done++; wr_data_seen = mem_wr_data; wr_addr_seen = mem_addr;
    end
    if (done) begin done_cnt++; done_cyc = cyc; if (error) err_cnt++; end
    if (error && !done) err_wo_done++;
    prev_wr_en   = mem_wr_en;
    prev_wr_data = mem_wr_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  int b_acc, b_rd, b_wen, b_wr, b_done, b_err, b_uns;
  task automatic snap();
    b_acc = accept_cnt; b_rd = rd_pulses; b_wen = wr_en_cyc; b_wr = wr_done;
    b_done = done_cnt; b_err = err_cnt; b_uns = unstable;
  endtask

  logic [31:0] sub_addr [4] = '{32'h202, 32'h200, 32'h203, 32'h200};
  logic [31:0] sub_data [4] = '{32'h0000BEEF, 32'h0000BEEF, 32'h00000055, 32'h12345699};
  logic [1:0]  sub_size [4] = '{2'd1, 2'd1, 2'd2, 2'd2};
  logic [31:0] sub_exp  [4] = '{32'h1122BEEF, 32'hBEEF3344, 32'h11223355, 32'h99223344};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    spur_ack = 1'b0; rd_lat = 0; ack_lat = 0; mem_word = 32'h11223344;
    model_rd_valid = 1'b0; model_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {27'd0, req_ready, done, error, mem_rd_en, mem_wr_en}, 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_wdata", mem_wr_data, 32'd0);
    rst = 1'b0; #1;
    check_eq("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Word store, immediate ack
    snap();
    do_store(32'h100, 32'hDEADBEEF, 2'd0);
    repeat (8) @(posedge clk);
    check_eq("word_data", wr_data_seen, 32'hDEADBEEF);
    check_eq("word_addr", wr_addr_seen, 32'h100);
    check_eq("word_writes", wr_done - b_wr, 1);
    check_eq("word_no_read", rd_pulses - b_rd, 0);
    check_eq("word_done", done_cnt - b_done, 1);
    check_eq("word_err", err_cnt - b_err, 0);
    check_eq("word_wr_lat", wr_cyc - accept_cyc, 1);
    check_eq("word_done_lat", done_cyc - accept_cyc, 2);

    // Byte RMW, read 3 cycles late, ack delayed 2
    rd_lat = 3; ack_lat = 2; snap();
    do_store(32'h201, 32'h000000AB, 2'd2);
    repeat (15) @(posedge clk);
    check_eq("sb_data", wr_data_seen, 32'h11AB3344);
    check_eq("sb_addr", wr_addr_seen, 32'h200);
    check_eq("sb_reads", rd_pulses - b_rd, 1);
    check_eq("sb_writes", wr_done - b_wr, 1);
    check_eq("sb_done", done_cnt - b_done, 1);
    check_eq("sb_stable", unstable - b_uns, 0);
    check_eq("sb_wen_cycles", wr_en_cyc - b_wen, 3);
    check_eq("sb_rd_lat", rd_cyc - accept_cyc, 1);
    check_eq("sb_ack_to_done", done_cyc - wr_cyc, 3);

    // Sub-word merges, zero-latency memory
    rd_lat = 0; ack_lat = 0;
    for (int i = 0; i < 4; i++) begin
      snap();
      do_store(sub_addr[i], sub_data[i], sub_size[i]);
      repeat (6) @(posedge clk);
      check_eq($sformatf("sub%0d_data", i), wr_data_seen, sub_exp[i]);
      check_eq($sformatf("sub%0d_done", i), done_cnt - b_done, 1);
      check_eq($sformatf("sub%0d_wr_lat", i), wr_cyc - accept_cyc, 2);
      check_eq($sformatf("sub%0d_done_lat", i), done_cyc - accept_cyc, 3);
    end

    // Misaligned half and illegal size
    for (int i = 0; i < 2; i++) begin
      snap();
      if (i == 0) do_store(32'h203, 32'h0000BEEF, 2'd1);
      else        do_store(32'h204, 32'h01020304, 2'd3);
      repeat (5) @(posedge clk);
      check_eq($sformatf("err%0d_done", i), done_cnt - b_done, 1);
      check_eq($sformatf("err%0d_flag", i), err_cnt - b_err, 1);
      check_eq($sformatf("err%0d_lat", i), done_cyc - accept_cyc, 1);
      check_eq($sformatf("err%0d_no_rd", i), rd_pulses - b_rd, 0);
      check_eq($sformatf("err%0d_no_wr", i), wr_en_cyc - b_wen, 0);
    end

    // Reset while waiting for read data
    rd_lat = 6; snap();
    do_store(32'h300, 32'h00000077, 2'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_ctrl", {27'd0, req_ready, done, error, mem_rd_en, mem_wr_en}, 32'd0);
    check_eq("midrst_addr", mem_addr, 32'd0);
    check_eq("midrst_wdata", mem_wr_data, 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    check_eq("midrst_no_done", done_cnt - b_done, 0);
    check_eq("midrst_no_wr", wr_en_cyc - b_wen, 0);
    rd_lat = 0; snap();
    do_store(32'h203, 32'h00000055, 2'd2);
    repeat (6) @(posedge clk);
    check_eq("post_rst_data", wr_data_seen, 32'h11223355);
    check_eq("post_rst_done", done_cnt - b_done, 1);

    // Request held high with changing payload while busy
    ack_lat = 1; snap();
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h400; req_data = 32'hCAFEF00D; req_size = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      req_addr = 32'h400 + 32'(i * 4); req_data = 32'h1111_1111 * 32'(i); req_size = 2'(i);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    check_eq("busy_accepts", accept_cnt - b_acc, 1);
    check_eq("busy_data", wr_data_seen, 32'hCAFEF00D);
    check_eq("busy_addr", wr_addr_seen, 32'h400);
    check_eq("busy_done", done_cnt - b_done, 1);

    // Spurious ack while idle
    ack_lat = 0; snap();
    @(posedge clk); #1; spur_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1; spur_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("spur_no_done", done_cnt - b_done, 0);
    check_eq("spur_no_wr", wr_en_cyc - b_wen, 0);
    check_eq("spur_ready", {31'd0, req_ready}, 32'd1);
    check_eq("error_only_with_done", err_wo_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
`default_nettype wire
